// File: rtl/ccw_output.sv
// ccw_output: counter-clockwise output port of the ring router.
// Each virtual channel (even/odd) has a single-entry output buffer fed by a
// two-way round-robin arbiter (ccw pass-through vs. PE injection). The hop
// field is decremented on capture. The buffered packet is driven onto the ccw
// link when the global polarity selects its VC and the downstream is ready.
module ccw_output #(
    parameter int DATA_WIDTH = 64,
    parameter int HOP_MSB    = 55,
    parameter int HOP_LSB    = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  polarity,
    input  logic                  request_ccw_even,
    input  logic                  request_ccw_odd,
    input  logic                  request_pe_even,
    input  logic                  request_pe_odd,
    input  logic [DATA_WIDTH-1:0] data_in_even_ccw,
    input  logic [DATA_WIDTH-1:0] data_in_odd_ccw,
    input  logic [DATA_WIDTH-1:0] data_in_even_pe,
    input  logic [DATA_WIDTH-1:0] data_in_odd_pe,
    output logic                  grant_ccw_even,
    output logic                  grant_ccw_odd,
    output logic                  grant_pe_even,
    output logic                  grant_pe_odd,
    output logic                  ccwso,
    input  logic                  ccwro,
    output logic [DATA_WIDTH-1:0] ccwdo
);

    localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

    // Decrement the hop field modulo 2^HOP_W; every other bit passes through.
    function automatic logic [DATA_WIDTH-1:0] hop_dec(input logic [DATA_WIDTH-1:0] pkt);
        logic [DATA_WIDTH-1:0] res;
        logic [HOP_W-1:0]      hop;
        res                   = pkt;
        hop                   = pkt[HOP_MSB:HOP_LSB];
        res[HOP_MSB:HOP_LSB]  = hop - HOP_W'(1);
        return res;
    endfunction

    // Two-requester round-robin grant: {ccw, pe}. pe_pri selects pe on a tie.
    function automatic logic [1:0] arb(input logic en, input logic avail,
                                       input logic req_ccw, input logic req_pe,
                                       input logic pe_pri);
        logic [1:0] g;
        g = 2'b00;
        if (en && avail) begin
            case ({req_ccw, req_pe})
                2'b10:   g = 2'b10;
                2'b01:   g = 2'b01;
                2'b11:   g = pe_pri ? 2'b01 : 2'b10;
                default: g = 2'b00;
            endcase
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    // Per-VC buffer state.
    logic                  full_even_r;
    logic                  full_odd_r;
    logic [DATA_WIDTH-1:0] data_even_r;
    logic [DATA_WIDTH-1:0] data_odd_r;
    logic                  rr_even_r;
    logic                  rr_odd_r;

    // Combinational link / grant signals.
    logic                  send_even_s;
    logic                  send_odd_s;
    logic                  avail_even_s;
    logic                  avail_odd_s;
    logic [1:0]            gnt_even_s;
    logic [1:0]            gnt_odd_s;
    logic [DATA_WIDTH-1:0] cap_even_s;
    logic [DATA_WIDTH-1:0] cap_odd_s;

    // Link send decision: a VC may only use the link in its own polarity phase.
    always_comb begin
        send_even_s  = ccwro & ~polarity & full_even_r;
        send_odd_s   = ccwro &  polarity & full_odd_r;
        ccwso        = send_even_s | send_odd_s;
        // A full buffer is reusable in the cycle it drains (pass-through).
        avail_even_s = ~full_even_r | send_even_s;
        avail_odd_s  = ~full_odd_r  | send_odd_s;
        if (send_odd_s) begin
            ccwdo = data_odd_r;
        end else if (send_even_s) begin
            ccwdo = data_even_r;
        end else begin
            ccwdo = {DATA_WIDTH{1'b0}};
        end
    end

    // Per-VC arbitration; grants are suppressed while reset is asserted.
    always_comb begin
        gnt_even_s     = arb(rst, avail_even_s, request_ccw_even, request_pe_even, rr_even_r);
        gnt_odd_s      = arb(rst, avail_odd_s,  request_ccw_odd,  request_pe_odd,  rr_odd_r);
        grant_ccw_even = gnt_even_s[1];
        grant_pe_even  = gnt_even_s[0];
        grant_ccw_odd  = gnt_odd_s[1];
        grant_pe_odd   = gnt_odd_s[0];
        cap_even_s     = hop_dec(gnt_even_s[1] ? data_in_even_ccw : data_in_even_pe);
        cap_odd_s      = hop_dec(gnt_odd_s[1]  ? data_in_odd_ccw  : data_in_odd_pe);
    end

    // Even-VC buffer: capture on grant, otherwise drain on send.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_even_r <= 1'b0;
            data_even_r <= {DATA_WIDTH{1'b0}};
            rr_even_r   <= 1'b0;
        end else if (|gnt_even_s) begin
            full_even_r <= 1'b1;
            data_even_r <= cap_even_s;
            rr_even_r   <= gnt_even_s[1];   // winner was ccw -> pe next
        end else if (send_even_s) begin
            full_even_r <= 1'b0;
        end else begin
            full_even_r <= full_even_r;
        end
    end

    // Odd-VC buffer: capture on grant, otherwise drain on send.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_odd_r <= 1'b0;
            data_odd_r <= {DATA_WIDTH{1'b0}};
            rr_odd_r   <= 1'b0;
        end else if (|gnt_odd_s) begin
            full_odd_r <= 1'b1;
            data_odd_r <= cap_odd_s;
            rr_odd_r   <= gnt_odd_s[1];
        end else if (send_odd_s) begin
            full_odd_r <= 1'b0;
        end else begin
            full_odd_r <= full_odd_r;
        end
    end

endmodule

// File: tb/tb_ccw_output.sv
// tb_ccw_output: directed scenarios plus randomized traffic for ccw_output,
// checked every cycle against a behavioural model of the output port.
module tb_ccw_output;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        polarity = 1'b0;
    logic        request_ccw_even = 1'b0, request_ccw_odd = 1'b0;
    logic        request_pe_even = 1'b0, request_pe_odd = 1'b0;
    logic [63:0] data_in_even_ccw = 64'd0, data_in_odd_ccw = 64'd0;
    logic [63:0] data_in_even_pe = 64'd0, data_in_odd_pe = 64'd0;
    logic        grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd;
    logic        ccwso;
    logic        ccwro = 1'b0;
    logic [63:0] ccwdo;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: per VC (index 0 = even, 1 = odd) occupancy, packet, and whether
    // the PE side wins the next tie.
    bit          m_full[2];
    logic [63:0] m_pkt[2];
    bit          m_pe_next[2];

    // Last observed DUT outputs, for directed checks.
    bit          obs_gc[2], obs_gp[2], obs_so;
    logic [63:0] obs_do;

    always #5 clk = ~clk;

    ccw_output dut (
        .clk(clk), .rst(rst), .polarity(polarity),
        .request_ccw_even(request_ccw_even), .request_ccw_odd(request_ccw_odd),
        .request_pe_even(request_pe_even), .request_pe_odd(request_pe_odd),
        .data_in_even_ccw(data_in_even_ccw), .data_in_odd_ccw(data_in_odd_ccw),
        .data_in_even_pe(data_in_even_pe), .data_in_odd_pe(data_in_odd_pe),
        .grant_ccw_even(grant_ccw_even), .grant_ccw_odd(grant_ccw_odd),
        .grant_pe_even(grant_pe_even), .grant_pe_odd(grant_pe_odd),
        .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo)
    );

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hop_minus_one(input logic [63:0] pkt);
        logic [63:0] r;
        r = pkt;
        r[55:48] = pkt[55:48] - 8'd1;
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle: drive inputs at the falling edge, check the
    // combinational outputs against the model, then advance the model.
    // rq = {ccw_even, ccw_odd, pe_even, pe_odd}.
    task automatic step(input bit r, input bit pol, input bit ro, input logic [3:0] rq,
                        input logic [63:0] dce, input logic [63:0] dco,
                        input logic [63:0] dpe, input logic [63:0] dpo);
        bit          send;
        bit          avail, rc, rp;
        bit          gc[2], gp[2];
        logic [63:0] exp_do;
        logic [63:0] dc[2], dp[2];
        @(negedge clk);
        rst = r; polarity = pol; ccwro = ro;
        request_ccw_even = rq[3]; request_ccw_odd = rq[2];
        request_pe_even  = rq[1]; request_pe_odd  = rq[0];
        data_in_even_ccw = dce; data_in_odd_ccw = dco;
        data_in_even_pe  = dpe; data_in_odd_pe  = dpo;
        dc[0] = dce; dc[1] = dco; dp[0] = dpe; dp[1] = dpo;
        if (!r) begin
            for (int v = 0; v < 2; v++) begin
                m_full[v] = 1'b0; m_pkt[v] = 64'd0; m_pe_next[v] = 1'b0;
            end
        end
        #1;
        send   = ro && m_full[pol];
        exp_do = send ? m_pkt[pol] : 64'd0;
        for (int v = 0; v < 2; v++) begin
            avail = !m_full[v] || (send && (pol == v[0]));
            rc    = (v == 0) ? rq[3] : rq[2];
            rp    = (v == 0) ? rq[1] : rq[0];
            gc[v] = r && avail && rc && (!rp || !m_pe_next[v]);
            gp[v] = r && avail && rp && (!rc || m_pe_next[v]);
        end
        check("grant_ccw_even", {63'd0, grant_ccw_even}, {63'd0, gc[0]});
        check("grant_pe_even",  {63'd0, grant_pe_even},  {63'd0, gp[0]});
        check("grant_ccw_odd",  {63'd0, grant_ccw_odd},  {63'd0, gc[1]});
        check("grant_pe_odd",   {63'd0, grant_pe_odd},   {63'd0, gp[1]});
        check("ccwso",          {63'd0, ccwso},          {63'd0, send});
        check("ccwdo",          ccwdo,                   exp_do);
        obs_gc[0] = grant_ccw_even; obs_gc[1] = grant_ccw_odd;
        obs_gp[0] = grant_pe_even;  obs_gp[1] = grant_pe_odd;
        obs_so = ccwso; obs_do = ccwdo;
        @(posedge clk);
        if (r) begin
            for (int v = 0; v < 2; v++) begin
                if (gc[v] || gp[v]) begin
                    m_pkt[v]     = hop_minus_one(gc[v] ? dc[v] : dp[v]);
                    m_full[v]    = 1'b1;
                    m_pe_next[v] = gc[v];
                end else if (send && (pol == v[0])) begin
                    m_full[v] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input bit r, input bit pol, input bit ro);
        step(r, pol, ro, 4'b0000, rnd64(), rnd64(), rnd64(), rnd64());
    endtask

    initial begin
        logic [63:0] pt_pkt;
        int          k;

        // Reset held with random requests and a ready link.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'($urandom), 1'b1, 4'($urandom), rnd64(), rnd64(), rnd64(), rnd64());
            check("rst_no_send", {63'd0, obs_so}, 64'd0);
        end

        // First packet after release, hop decrement, phase gating.
        step(1'b1, 1'b1, 1'b1, 4'b1000, 64'h0005_0000_0000_00AA, rnd64(), rnd64(), rnd64());
        check("first_grant", {63'd0, obs_gc[0]}, 64'd1);
        idle(1'b1, 1'b1, 1'b1);
        check("odd_phase_idle", {63'd0, obs_so}, 64'd0);
        idle(1'b1, 1'b0, 1'b1);
        check("hop_dec_send", obs_do, 64'h0004_0000_0000_00AA);

        // Arbitration on the odd VC with both requesters held.
        idle(1'b0, 1'b0, 1'b1);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'(i % 2), 1'b1, 4'b0101, rnd64(), rnd64(), rnd64(), rnd64());
            if (obs_gc[1] || obs_gp[1]) begin
                check("arb_order", {62'd0, obs_gc[1], obs_gp[1]},
                      (k % 2 == 0) ? 64'd2 : 64'd1);
                k++;
            end
        end
        check("arb_count", 64'(k), 64'd7);

        // Backpressure: fill both VCs, then hold the link not-ready.
        idle(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'b1001, rnd64(), rnd64(), rnd64(), rnd64());
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom), 1'b0, 4'($urandom), rnd64(), rnd64(), rnd64(), rnd64());
            check("bp_no_grant", {60'd0, obs_gc[0], obs_gp[0], obs_gc[1], obs_gp[1]}, 64'd0);
        end
        idle(1'b1, 1'b1, 1'b1);
        check("bp_odd_sent", {63'd0, obs_so}, 64'd1);
        idle(1'b1, 1'b0, 1'b1);
        check("bp_even_sent", {63'd0, obs_so}, 64'd1);

        // Pass-through on the odd VC.
        step(1'b1, 1'b0, 1'b1, 4'b0001, rnd64(), rnd64(), rnd64(), rnd64());
        pt_pkt = rnd64();
        step(1'b1, 1'b1, 1'b1, 4'b0001, rnd64(), rnd64(), rnd64(), pt_pkt);
        check("pt_send_and_grant", {62'd0, obs_so, obs_gp[1]}, 64'd3);
        idle(1'b1, 1'b1, 1'b1);
        check("pt_next_packet", obs_do, hop_minus_one(pt_pkt));

        // Hop wrap 0x00 -> 0xFF.
        step(1'b1, 1'b1, 1'b1, 4'b1000, 64'h1200_0000_DEAD_BEEF, rnd64(), rnd64(), rnd64());
        idle(1'b1, 1'b0, 1'b1);
        check("hop_wrap", obs_do, 64'h12FF_0000_DEAD_BEEF);

        // Reset mid-flight with both buffers full.
        step(1'b1, 1'b0, 1'b0, 4'b1001, rnd64(), rnd64(), rnd64(), rnd64());
        idle(1'b0, 1'b1, 1'b1);
        check("rst_mid_drop", {63'd0, obs_so}, 64'd0);
        idle(1'b1, 1'b1, 1'b1);
        check("no_stale_odd", {63'd0, obs_so}, 64'd0);
        idle(1'b1, 1'b0, 1'b1);
        check("no_stale_even", {63'd0, obs_so}, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(63, 0) != 0), 1'($urandom), 1'($urandom_range(3, 0) != 0),
                 4'($urandom), rnd64(), rnd64(), rnd64(), rnd64());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ccw_output.md
# ccw_output

Counter-clockwise output port of the ring router. It arbitrates between the ccw input buffer (pass-through traffic) and the PE injection port for each virtual channel (even/odd), and holds one packet per VC in a single-entry output buffer. It decrements the hop field and drives the ccw link (`ccwso`/`ccwdo`) toward the next router's ccw input, subject to the link ready `ccwro` and the global `polarity` phase.

## Interface
- `DATA_WIDTH`, 64, packet width.
- `HOP_MSB`, 55, hop-count field MSB.
- `HOP_LSB`, 48, hop-count field LSB.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `polarity`  in  1  global VC phase; 1 = odd VC owns the link this cycle, 0 = even.
- `request_ccw_even`, `request_ccw_odd`  in  1  requests from the ccw input buffer.
- `request_pe_even`, `request_pe_odd`  in  1  requests from the PE injection port.
- `data_in_even_ccw`, `data_in_odd_ccw`, `data_in_even_pe`, `data_in_odd_pe`  in  DATA_WIDTH  packet offered with the matching request.
- `grant_ccw_even`, `grant_ccw_odd`, `grant_pe_even`, `grant_pe_odd`  out  1  combinational grants; one-cycle pulse per accepted packet.
- `ccwso`  out  1  link send strobe.
- `ccwro`  in  1  downstream ready (registered by downstream).
- `ccwdo`  out  DATA_WIDTH  link data.

## Operation
- Each VC has an independent single-entry buffer (`full` flag plus data register), a round-robin pointer (`rr`: 0 = ccw wins, 1 = pe wins), and a grant path.
- Buffer available for VC v in a cycle: `~full_v`, or `full_v` while this same cycle sends v on the link (pass-through).
- Grants (combinational, per VC):
  - Only one requester active and the buffer is available: grant it.
  - Both requesters active and the buffer is available: grant the requester selected by `rr_v`.
  - Buffer unavailable: no grant. Requesters hold their request.
  - At most one grant per VC per cycle. The even and odd VCs may both grant in the same cycle.
- On a granted edge:
  - The buffer captures the selected data with field [HOP_MSB:HOP_LSB] replaced by field−1 (mod 256; 0 wraps to 255, no flag).
  - `full_v` is set to 1.
  - `rr_v` is set to point at the non-granted requester.
- A single-requester grant also flips `rr_v` away from the winner.
- Link send, combinational:
  - `ccwso = ccwro & (polarity ? full_odd : full_even)`.
  - `ccwdo` = the selected buffer's data when `ccwso` = 1, else 0.
- On an edge with `ccwso` = 1, the sent VC's `full` clears, unless the same edge captures a new packet for that VC (pass-through). In that case `full` stays 1 with the new data.
- `ccwro` = 0: nothing is sent, buffers hold, and grants are issued only to empty buffers.
- No VC swap: even-VC packets are only sent in `polarity`=0 cycles, odd-VC packets only in `polarity`=1 cycles.

## Timing
- Reset (asynchronous assert, synchronous-edge release): `full_even`=`full_odd`=0, both data registers=0, `rr_even`=`rr_odd`=0. This gives `ccwso`=0, `ccwdo`=0, and all grants 0 while `rst`=0.
- Reset mid-operation discards buffered packets immediately. No send occurs in the reset cycle.
- Grant latency: 0 cycles (same cycle as request when the buffer is available). Data is captured at the closing edge of the grant cycle.
- Send latency: a packet captured at edge E is sent in the first cycle after E whose `polarity` matches its VC with `ccwro`=1. The minimum is 1 cycle after capture.
- Throughput: one packet per VC per matching-polarity cycle via pass-through. The link carries at most one packet per cycle.
- Comb paths: `ccwro`/`polarity` → `ccwso`/`ccwdo`/grants; requests → grants. There is no path from a grant to a request within this block.

## Test plan
- Reset: hold `rst`=0 with random requests and `ccwro`=1 → all grants 0, `ccwso`=0, `ccwdo`=0. Release, then request_ccw_even with data hop=0x05 → `grant_ccw_even`=1 same cycle.
- Hop and phase: ccw_even packet 0x00_05_..._AA granted; next `polarity`=0 cycle with `ccwro`=1 → `ccwso`=1, `ccwdo` hop field=0x04, other bits unchanged. `polarity`=1 cycles → `ccwso`=0.
- Arbitration: both `request_ccw_odd` and `request_pe_odd` held high, `polarity` toggling, `ccwro`=1 → grants alternate ccw, pe, ccw, pe; the first grant after reset goes to ccw.
- Backpressure: fill both VCs, hold `ccwro`=0 for 10 cycles → `ccwso`=0, no grants, data held. Raise `ccwro` → even sent in the first `polarity`=0 cycle, odd in the first `polarity`=1 cycle.
- Pass-through: odd buffer full, `polarity`=1, `ccwro`=1, `request_pe_odd`=1 → send and `grant_pe_odd` in the same cycle; the next odd send carries the PE packet.
- Wrap and reset mid-flight: inject hop=0x00 → sent with hop=0xFF. With both buffers full, pulse `rst` low mid-cycle → `ccwso` drops immediately and no stale packet is sent after release.
